// File: rtl/hack_vga_pkg.sv
// Shared 640x480@60 timing constants, Hack screen geometry and colours for the screen scanner.
package hack_vga_pkg;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FRONT   = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BACK    = 10'd48;
    localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FRONT   = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BACK    = 10'd33;
    localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] HACK_SCREEN_W = 10'd512;
    localparam logic [9:0] HACK_SCREEN_H = 10'd256;
    localparam int         WORDS_PER_ROW = 32;

    // Ticks between a fetch and the first pixel of the fetched word.
    localparam int FETCH_LEAD = 2;

    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_WHITE = 3'b111;
    localparam logic [2:0] RGB_BLUE  = 3'b001;

    typedef enum logic [1:0] {
        REGION_BLANK,
        REGION_BORDER,
        REGION_WINDOW
    } region_e;

    function automatic logic in_span(input logic [9:0] x, input logic [9:0] lo, input logic [9:0] len);
        return (x >= lo) && ((x - lo) < len);
    endfunction

endpackage

// File: rtl/hack_vga_timing.sv
// Horizontal/vertical pixel counters with combinational sync and visible-area flags.
module hack_vga_timing
    import hack_vga_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       visible
);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == H_TOTAL - 10'd1) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_TOTAL - 10'd1) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt   = h_cnt_q;
    assign v_cnt   = v_cnt_q;
    assign hsync_n = !in_span(h_cnt_q, H_VISIBLE + H_FRONT, H_SYNC);
    assign vsync_n = !in_span(v_cnt_q, V_VISIBLE + V_FRONT, V_SYNC);
    assign visible = (h_cnt_q < H_VISIBLE) && (v_cnt_q < V_VISIBLE);

endmodule

// File: rtl/hack_screen_scanner.sv
// VGA scanner for the 512x256 Hack screen: fetch scheduling, word serializer and colour mux.
// Define HACK_SCAN_BORDER_EN to paint the visible area around the Hack window blue.
module hack_screen_scanner
    import hack_vga_pkg::*;
#(
    parameter int H_OFFSET = 64,
    parameter int V_OFFSET = 112
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_en,
    output logic        rd_en,
    output logic [12:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  rgb,
    output logic        frame_start
);

`ifdef HACK_SCAN_BORDER_EN
    localparam logic [2:0] RGB_BORDER = RGB_BLUE;
`else
    localparam logic [2:0] RGB_BORDER = RGB_BLACK;
`endif

    localparam logic [9:0] WIN_X0   = 10'(H_OFFSET);
    localparam logic [9:0] WIN_Y0   = 10'(V_OFFSET);
    localparam logic [9:0] FETCH_X0 = 10'(H_OFFSET - FETCH_LEAD);

    logic [9:0] h_cnt, v_cnt;
    logic       tm_hsync_n, tm_vsync_n, tm_visible;

    hack_vga_timing u_timing (
        .clock   (clock),
        .reset   (reset),
        .pix_en  (pix_en),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .hsync_n (tm_hsync_n),
        .vsync_n (tm_vsync_n),
        .visible (tm_visible)
    );

    logic [9:0]  wx, wy, fx;
    logic        win_line, win_col, fetch_hit;
    region_e     region;
    logic        pixel;

    logic        rd_en_q, rd_en_d;
    logic [12:0] rd_addr_q, rd_addr_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] shreg_q, shreg_d;

    assign wx        = h_cnt - WIN_X0;
    assign wy        = v_cnt - WIN_Y0;
    assign fx        = h_cnt - FETCH_X0;
    assign win_line  = in_span(v_cnt, WIN_Y0, HACK_SCREEN_H);
    assign win_col   = in_span(h_cnt, WIN_X0, HACK_SCREEN_W);
    // The fetch span is the window shifted left by the lead, one trigger per 16-pixel word.
    assign fetch_hit = win_line && in_span(h_cnt, FETCH_X0, HACK_SCREEN_W) && (fx[3:0] == 4'd0);

    always_comb begin
        rd_en_d       = 1'b0;
        rd_addr_d     = rd_addr_q;
        frame_start_d = 1'b0;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        rgb_d         = rgb_q;
        shreg_d       = shreg_q;
        pixel         = 1'b0;
        region        = REGION_BLANK;

        if (tm_visible) begin
            region = (win_line && win_col) ? REGION_WINDOW : REGION_BORDER;
        end

        if (pix_en) begin
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
            hsync_d       = tm_hsync_n;
            vsync_d       = tm_vsync_n;

            if (fetch_hit) begin
                rd_en_d   = 1'b1;
                rd_addr_d = {wy[7:0], fx[8:4]};
            end

            if (region == REGION_WINDOW) begin
                if (wx[3:0] == 4'd0) begin
                    pixel   = rd_data[0];
                    shreg_d = rd_data >> 1;
                end else begin
                    pixel   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end

            case (region)
                REGION_WINDOW: rgb_d = pixel ? RGB_BLACK : RGB_WHITE;
                REGION_BORDER: rgb_d = RGB_BORDER;
                default:       rgb_d = RGB_BLACK;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= RGB_BLACK;
            frame_start_q <= 1'b0;
            shreg_q       <= '0;
        end else begin
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            shreg_q       <= shreg_d;
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hack_screen_scanner.sv
// Self-checking bench for hack_screen_scanner: behavioural pixel/fetch model, vector table and reset corner cases.
// The window is moved to line 2 so window lines are reachable within a short run.
module tb_hack_screen_scanner;

    localparam int H_OFF      = 64;
    localparam int V_OFF      = 2;
    localparam int RUN1_TICKS = 6 * 800;

`ifdef HACK_SCAN_BORDER_EN
    localparam logic [2:0] BORDER = 3'b001;
`else
    localparam logic [2:0] BORDER = 3'b000;
`endif

    typedef struct packed {
        logic [2:0]  rgb;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        rd_en;
        logic [12:0] addr;
    } out_t;

    typedef struct {
        string      name;
        int         h;
        int         v;
        logic [2:0] rgb;
        logic       hs;
        logic       fs;
    } vec_t;

    localparam out_t RESET_OUT = '{rgb: 3'b000, hs: 1'b1, vs: 1'b1, fs: 1'b0, rd_en: 1'b0, addr: 13'd0};

    logic        clock = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        rd_en;
    logic [12:0] rd_addr;
    logic [15:0] rd_data = 16'h0000;
    logic        hsync;
    logic        vsync;
    logic [2:0]  rgb;
    logic        frame_start;

    logic [15:0] mem [8192];
    out_t        log1 [RUN1_TICKS];
    vec_t        vecs [$];

    int          checks = 0;
    int          passes = 0;
    int          n;
    logic [12:0] model_addr;
    out_t        last_exp;
    int          line_errs;
    string       first_err;
    string       phase_name;
    logic        logging = 1'b0;

    hack_screen_scanner #(.H_OFFSET(H_OFF), .V_OFFSET(V_OFF)) dut (
        .clock       (clock),
        .reset       (reset),
        .pix_en      (pix_en),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    function automatic logic [2:0] modelRgb(input int h, input int v);
        int         wx, wy;
        logic [15:0] w;
        if (h >= 640 || v >= 480) return 3'b000;
        wx = h - H_OFF;
        wy = v - V_OFF;
        if (wx < 0 || wx >= 512 || wy < 0 || wy >= 256) return BORDER;
        w = mem[wy * 32 + wx / 16];
        return w[wx % 16] ? 3'b000 : 3'b111;
    endfunction

    function automatic out_t modelTick(input int idx, input logic [12:0] prev_addr);
        out_t e;
        int   h, v, fx;
        h       = idx % 800;
        v       = (idx / 800) % 525;
        fx      = h - (H_OFF - 2);
        e.rgb   = modelRgb(h, v);
        e.hs    = !(h >= 656 && h <= 751);
        e.vs    = !(v >= 490 && v <= 491);
        e.fs    = (h == 0 && v == 0);
        e.rd_en = (v >= V_OFF && v < V_OFF + 256 && fx >= 0 && fx < 512 && fx % 16 == 0);
        e.addr  = e.rd_en ? 13'((v - V_OFF) * 32 + fx / 16) : prev_addr;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic closeLine(input string name);
        checks++;
        if (line_errs == 0) passes++;
        else $display("[TB] FAIL %s: %0d mismatching samples, expected 0; first %s", name, line_errs, first_err);
        line_errs = 0;
    endtask

    task automatic resetModel();
        n          = 0;
        model_addr = '0;
        last_exp   = RESET_OUT;
        line_errs  = 0;
    endtask

    task automatic addVec(input string name, input int h, input int v, input logic [2:0] c,
                          input logic hs, input logic fs);
        vec_t t;
        t.name = name; t.h = h; t.v = v; t.rgb = c; t.hs = hs; t.fs = fs;
        vecs.push_back(t);
    endtask

    // One clock; on a tick the model advances, otherwise outputs must hold with pulses dropped.
    task automatic applyStimulus(input logic tick);
        out_t exp_o, act_o;
        int   h, v;
        @(negedge clock);
        pix_en = tick;
        @(posedge clock);
        #1;
        act_o = {rgb, hsync, vsync, frame_start, rd_en, rd_addr};
        h = -1;
        v = (n / 800) % 525;
        if (tick) begin
            h          = n % 800;
            exp_o      = modelTick(n, model_addr);
            model_addr = exp_o.addr;
            last_exp   = exp_o;
            if (logging && n < RUN1_TICKS) log1[n] = act_o;
            n++;
        end else begin
            exp_o       = last_exp;
            exp_o.fs    = 1'b0;
            exp_o.rd_en = 1'b0;
        end
        if (act_o !== exp_o) begin
            line_errs++;
            if (line_errs == 1)
                first_err = $sformatf("at h=%0d v=%0d tick=%0d got %h expected %h", h, v, tick, act_o, exp_o);
        end
        if (tick && h == 799) closeLine($sformatf("%s_line%0d", phase_name, v));
    endtask

    initial begin
        int   idx, cyc;
        int   cnt, first_h, last_h, first_a, last_a, lows, fs_cnt;
        out_t o;

        reset  = 1'b1;
        pix_en = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom());
        mem[0] = 16'h0001;

        addVec("origin",        0,   0, BORDER, 1'b1, 1'b1);
        addVec("after_origin",  1,   0, BORDER, 1'b1, 1'b0);
        addVec("border_10_1",  10,   1, BORDER, 1'b1, 1'b0);
        addVec("pre_win_line", 64,   1, BORDER, 1'b1, 1'b0);
        addVec("last_visible", 639,  1, BORDER, 1'b1, 1'b0);
        addVec("front_porch",  640,  1, 3'b000, 1'b1, 1'b0);
        addVec("porch_end",    655,  1, 3'b000, 1'b1, 1'b0);
        addVec("sync_first",   656,  1, 3'b000, 1'b0, 1'b0);
        addVec("sync_last",    751,  1, 3'b000, 1'b0, 1'b0);
        addVec("back_porch",   752,  1, 3'b000, 1'b1, 1'b0);
        addVec("line_end",     799,  1, 3'b000, 1'b1, 1'b0);
        addVec("win_left_out",  63,  2, BORDER, 1'b1, 1'b0);
        addVec("word0_bit0",    64,  2, 3'b000, 1'b1, 1'b0);
        addVec("word0_bit1",    65,  2, 3'b111, 1'b1, 1'b0);
        addVec("word0_bit15",   79,  2, 3'b111, 1'b1, 1'b0);
        addVec("win_right_out", 576, 2, BORDER, 1'b1, 1'b0);

        // Reset held with pix_en high must keep every output at its reset value.
        repeat (2) @(posedge clock);
        @(negedge clock);
        pix_en = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        checkOutput("reset_outputs", int'({rgb, hsync, vsync, frame_start, rd_en, rd_addr}), int'(RESET_OUT));
        @(negedge clock);
        reset  = 1'b0;
        pix_en = 1'b0;

        resetModel();
        phase_name = "full";
        logging    = 1'b1;
        for (int i = 0; i < RUN1_TICKS; i++) applyStimulus(1'b1);
        logging = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            idx = vecs[i].v * 800 + vecs[i].h;
            checkOutput({vecs[i].name, "_rgb"}, int'(log1[idx].rgb), int'(vecs[i].rgb));
            checkOutput({vecs[i].name, "_hsync"}, int'(log1[idx].hs), int'(vecs[i].hs));
            checkOutput({vecs[i].name, "_frame_start"}, int'(log1[idx].fs), int'(vecs[i].fs));
        end

        fs_cnt = 0;
        for (int l = 0; l < 6; l++) begin
            cnt = 0; first_h = -1; last_h = -1; first_a = -1; last_a = -1; lows = 0;
            for (int h = 0; h < 800; h++) begin
                o = log1[l * 800 + h];
                if (o.rd_en) begin
                    cnt++;
                    if (first_h < 0) begin
                        first_h = h;
                        first_a = int'(o.addr);
                    end
                    last_h = h;
                    last_a = int'(o.addr);
                end
                if (!o.hs) lows++;
                if (o.fs) fs_cnt++;
                if (!o.vs) lows = lows + 1000;
            end
            checkOutput($sformatf("fetch_count_line%0d", l), cnt, (l < V_OFF) ? 0 : 32);
            checkOutput($sformatf("hsync_low_line%0d", l), lows, 96);
            if (l == 2 || l == 5) begin
                checkOutput($sformatf("first_fetch_h_line%0d", l), first_h, 62);
                checkOutput($sformatf("last_fetch_h_line%0d", l), last_h, 558);
                checkOutput($sformatf("first_addr_line%0d", l), first_a, (l - V_OFF) * 32);
                checkOutput($sformatf("last_addr_line%0d", l), last_a, (l - V_OFF) * 32 + 31);
            end
        end
        checkOutput("frame_start_pulses", fs_cnt, 1);

        // Third-rate ticks, then reset right after a fetch tick while rd_en is high.
        @(negedge clock);
        reset  = 1'b1;
        pix_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        resetModel();
        phase_name = "third";
        cyc = 0;
        while (n < 4 * 800 + 303) begin
            applyStimulus(cyc % 3 == 0);
            cyc++;
        end
        closeLine("third_line4_partial");
        checkOutput("pending_fetch_before_reset", int'(rd_en), 1);
        reset = 1'b1;
        #1;
        checkOutput("reset_kills_fetch", int'(rd_en), 0);
        checkOutput("reset_addr", int'(rd_addr), 0);
        checkOutput("midframe_reset_outputs", int'({rgb, hsync, vsync, frame_start, rd_en, rd_addr}), int'(RESET_OUT));
        @(negedge clock);
        pix_en = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        checkOutput("reset_hold_outputs", int'({rgb, hsync, vsync, frame_start, rd_en, rd_addr}), int'(RESET_OUT));
        @(negedge clock);
        reset  = 1'b0;
        pix_en = 1'b0;

        resetModel();
        phase_name = "restart";
        cyc = 0;
        while (n < 3 * 800) begin
            applyStimulus(cyc % 3 == 0);
            cyc++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hack_screen_scanner.md
# hack_screen_scanner

Display-side controller for the Hack screen memory. It generates 640x480@60 VGA timing and sequences read requests into the read-only port of the screen buffer. It serializes each 16-bit word into pixels and centers the 512x256 Hack screen in the visible area. It sits between `hack_screen_buffer` port B and the top-level `hsync`/`vsync`/`rgb` pins.

## Interface
Parameters:
- `H_OFFSET`, default 64: first visible column of the Hack window.
- `V_OFFSET`, default 112: first visible line of the Hack window.

Ports:
- `clock` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `pix_en` in 1: pixel tick; one-clock pulse per pixel (25 MHz rate).
- `rd_en` out 1: read request to the screen buffer; one clock wide.
- `rd_addr` out 13: screen word address, `row*32 + col`.
- `rd_data` in 16: buffer read data; valid the clock after `rd_en` and held until the next read.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `rgb` out 3: pixel colour.
- `frame_start` out 1: one-clock pulse on the tick where `h_cnt`=0 and `v_cnt`=0.

## Operation
- Counters:
  - `h_cnt` runs 0..799 and wraps to 0; `v_cnt` advances when `h_cnt` wraps and runs 0..524.
  - Both change only on `pix_en`.
- Horizontal timing: visible 0..639, front porch 640..655, sync 656..751 (`hsync`=0), back porch 752..799.
- Vertical timing: visible 0..479, front porch 480..489, sync 490..491 (`vsync`=0), back porch 492..524.
- Hack window: `h_cnt` in [H_OFFSET, H_OFFSET+511] and `v_cnt` in [V_OFFSET, V_OFFSET+255].
  - `wx = h_cnt - H_OFFSET`, `wy = v_cnt - V_OFFSET`.
- Fetch schedule, on window lines only:
  - Trigger: a tick with `h_cnt = H_OFFSET - 2 + 16k`, k = 0..31.
  - Response: the next clock drives `rd_en`=1 with `rd_addr = wy*32 + k`.
  - This gives 32 fetches per line. No fetch occurs outside window lines.
- Serializer:
  - On a tick with `wx mod 16 = 0` inside the window: pixel = `rd_data[0]` and `shreg <= rd_data >> 1`.
  - On other window ticks: pixel = `shreg[0]` and `shreg` shifts right by 1.
  - Bit 0 is the leftmost pixel.
- Colour:
  - Window pixel 1 → `rgb`=000 (black); window pixel 0 → `rgb`=111 (white).
  - Visible area outside the window: border colour (see Configuration).
  - Blanking: `rgb`=000.
- Address arithmetic: `rd_addr` is 13 bits unsigned. `wy*32 + k` never exceeds 8191, so it never wraps.
- Reset values:
  - Counters 0, `shreg` 0.
  - `hsync`=1, `vsync`=1, `rgb`=000, `rd_en`=0, `rd_addr`=0, `frame_start`=0.
- Reset mid-frame: all state returns to reset values immediately, including any pending fetch. Scanning restarts at (0,0) on the first tick after release.

## Timing
- `hsync`, `vsync`, `rgb` and `frame_start` are registered.
- Each updates on the clock edge of the `pix_en` tick, from the counter values before the advance, so all three video outputs stay mutually aligned.
- `rd_en` is high for exactly one clock, the clock following the fetch tick.
- The fetch lead of two ticks guarantees `rd_data` is valid at the load tick even when `pix_en` is high every clock.
- With gaps between ticks, `rd_data` holds its value, so the serializer is unaffected.
- If `pix_en` stays low, every output holds its value, except `rd_en` and `frame_start`, which drop after one clock.

## Configuration
- `HACK_SCAN_BORDER_EN` defined: visible pixels outside the Hack window drive `rgb`=001 (blue).
- Not defined: those pixels drive `rgb`=000.
- Timing and fetch behaviour are identical in both builds.

## Structure
- Package `hack_vga_pkg` holds the shared constants:
  - horizontal and vertical visible, porch, sync and total counts;
  - `HACK_SCREEN_W`=512, `HACK_SCREEN_H`=256, `WORDS_PER_ROW`=32;
  - the colour constants.
- Sub-module `hack_vga_timing` owns `h_cnt`, `v_cnt` and the sync/visible flags.
- The top of the block owns the fetch scheduler, the serializer and the colour mux.

## Test plan
- Reset with `pix_en` held at 1 → after release, `hsync`=1 and `vsync`=1; `frame_start` pulses at tick 0 and again after exactly 420000 ticks.
- Free run → `hsync` low for `h_cnt` 656..751 (96 ticks) in every 800-tick line; `vsync` low for exactly lines 490..491.
- Line `v_cnt`=112 → 32 `rd_en` pulses, `rd_addr` 0..31, first at `h_cnt`=62 and then every 16 ticks. Line 367 → addresses 8160..8191. Line 111 and line 368 → no `rd_en`.
- Memory model with word 0 = 16'h0001, all other words 0 → `rgb`=000 at (64,112), then 111 for `h_cnt` 65..79.
- `HACK_SCAN_BORDER_EN` on vs off → `rgb`=001 vs 000 at (10,10); `rgb`=000 during blanking in both builds.
- `pix_en` every third clock, plus `reset` asserted at `h_cnt`=300 on line 200 → pixel pattern identical to the full-rate run; after reset, counters restart at 0 and no stray `rd_en` appears.
